phase_clock_monitor: RTL and testbench

PHASE_CLOCK_MONITOR -- requirements
Module: phase_clock_monitor

---
 rtl/phase_mon_pkg.sv | 69 ++++++
 rtl/phase_dwell_timer.sv | 51 +++++
 rtl/phase_clock_monitor.sv | 125 ++++++++++++
 tb/tb_phase_clock_monitor.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/phase_mon_pkg.sv
// Shared definitions for the three-phase clock monitor: state encoding,
// the expected {I1,I2,I3} vector and nominal dwell for each phase, and
// the fault codes reported on err_code.
package phase_mon_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_P1,
        ST_P2,
        ST_P3,
        ST_P4,
        ST_P5,
        ST_P6,
        ST_P7,
        ST_RESYNC
    } phase_state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_SHORT   = 2'd2;
    localparam logic [1:0] ERR_LONG    = 2'd3;

    localparam int         DWELL_W   = 6;
    localparam logic [5:0] DWELL_MAX = 6'd63;

    // Vector that must be present on {I1,I2,I3} while in a given state
    function automatic logic [2:0] expected_vec(input phase_state_t s);
        logic [2:0] v;
        case (s)
            ST_P1:   v = 3'b001;
            ST_P2:   v = 3'b101;
            ST_P3:   v = 3'b100;
            ST_P4:   v = 3'b110;
            ST_P5:   v = 3'b010;
            ST_P6:   v = 3'b011;
            ST_P7:   v = 3'b001;
            default: v = 3'b000;
        endcase
        return v;
    endfunction

    // Nominal number of samples each phase is held; zero means unbounded
    function automatic logic [5:0] nominal_dwell(input phase_state_t s);
        logic [5:0] n;
        case (s)
            ST_P1, ST_P7:                      n = 6'd10;
            ST_P2, ST_P3, ST_P4, ST_P5, ST_P6: n = 6'd5;
            default:                           n = 6'd0;
        endcase
        return n;
    endfunction

    // Successor in the legal frame sequence; P7 closes the frame back to IDLE
    function automatic phase_state_t next_phase(input phase_state_t s);
        phase_state_t n;
        case (s)
            ST_IDLE: n = ST_P1;
            ST_P1:   n = ST_P2;
            ST_P2:   n = ST_P3;
            ST_P3:   n = ST_P4;
            ST_P4:   n = ST_P5;
            ST_P5:   n = ST_P6;
            ST_P6:   n = ST_P7;
            default: n = ST_IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/phase_dwell_timer.sv
// Dwell counter for the phase clock monitor. Counts consecutive samples of
// the current phase vector and flags a phase that was left too early
// (short) or has been held too long (long). Only used when the
// PHASE_MON_TIMING_EN macro is defined.
import phase_mon_pkg::*;

module phase_dwell_timer #(
    parameter int DWELL_TOL = 1
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       change,
    input  logic       active,
    input  logic [5:0] nominal,
    output logic       short_err,
    output logic       long_err
);

    // dwell_q holds the run length of the previous sample, so on a change it
    // is exactly the dwell of the phase being left
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] dwell_d;
    logic [DWELL_W-1:0] run_now;

    // Restart on every change, count while a phase is active, saturate at max
    always_comb begin
        dwell_d = '0;
        if (change) begin
            dwell_d = 6'd1;
        end else if (active) begin
            dwell_d = (dwell_q == DWELL_MAX) ? DWELL_MAX : dwell_q + 6'd1;
        end
    end

    // Dwell register
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            dwell_q <= '0;
        end else begin
            dwell_q <= dwell_d;
        end
    end

    // Short: phase left before nominal-tol samples; long: current run hits nominal+tol+1
    always_comb begin
        run_now   = (dwell_q == DWELL_MAX) ? DWELL_MAX : dwell_q + 6'd1;
        short_err = change && active && ((int'(dwell_q) + DWELL_TOL) < int'(nominal));
        long_err  = !change && active && (int'(run_now) >= (int'(nominal) + DWELL_TOL + 1));
    end

endmodule

// File: rtl/phase_clock_monitor.sv
// Three-phase clock sequence monitor. Samples {I1,I2,I3}, follows the
// IDLE->P1..P7->IDLE frame, pulses frame_done on a good frame and
// frame_err on an illegal vector. Define PHASE_MON_TIMING_EN to add
// short/long dwell checking through phase_dwell_timer.
import phase_mon_pkg::*;

module phase_clock_monitor #(
    parameter int DWELL_TOL = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             I1,
    input  logic             I2,
    input  logic             I3,
    output logic             busy,
    output logic             frame_done,
    output logic             frame_err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] frame_count
);

    logic [2:0]       v_q, v_d;
    logic [2:0]       v_prev_q, v_prev_d;
    phase_state_t     state_q, state_d;
    logic             frame_done_q, frame_done_d;
    logic             frame_err_q, frame_err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [CNT_W-1:0] frame_count_q, frame_count_d;
    logic             change;
    logic             short_err;
    logic             long_err;

    // Sample the phase inputs once and keep the previous sample for change detection
    always_comb begin
        v_d      = {I1, I2, I3};
        v_prev_d = v_q;
        change   = (v_q != v_prev_q);
        busy     = (state_q != ST_IDLE) && (state_q != ST_RESYNC);
    end

`ifdef PHASE_MON_TIMING_EN
    phase_dwell_timer #(
        .DWELL_TOL (DWELL_TOL)
    ) u_dwell_timer (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .change    (change),
        .active    (busy),
        .nominal   (nominal_dwell(state_q)),
        .short_err (short_err),
        .long_err  (long_err)
    );
`else
    assign short_err = 1'b0;
    assign long_err  = 1'b0;
`endif

    // Frame sequencing; IDLE shares the phase path since its successor is P1
    // and the dwell checks never fire outside P1..P7
    always_comb begin
        state_d       = state_q;
        frame_done_d  = 1'b0;
        frame_err_d   = 1'b0;
        err_code_d    = err_code_q;
        frame_count_d = frame_count_q;
        case (state_q)
            ST_RESYNC: begin
                if (v_q == 3'b000) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                if (change) begin
                    if (v_q != expected_vec(next_phase(state_q))) begin
                        state_d     = ST_RESYNC;
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_ILLEGAL;
                    end else if (short_err) begin
                        state_d     = ST_RESYNC;
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_SHORT;
                    end else begin
                        state_d = next_phase(state_q);
                        if (state_q == ST_P7) begin
                            frame_done_d  = 1'b1;
                            frame_count_d = frame_count_q + CNT_W'(1);
                        end
                    end
                end else if (long_err) begin
                    state_d     = ST_RESYNC;
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_LONG;
                end
            end
        endcase
    end

    // State, sample and output registers
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            v_q           <= 3'b000;
            v_prev_q      <= 3'b000;
            state_q       <= ST_IDLE;
            frame_done_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            err_code_q    <= ERR_NONE;
            frame_count_q <= '0;
        end else begin
            v_q           <= v_d;
            v_prev_q      <= v_prev_d;
            state_q       <= state_d;
            frame_done_q  <= frame_done_d;
            frame_err_q   <= frame_err_d;
            err_code_q    <= err_code_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign frame_done  = frame_done_q;
    assign frame_err   = frame_err_q;
    assign err_code    = err_code_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_phase_clock_monitor.sv
// Self-checking bench for phase_clock_monitor (CNT_W=2, DWELL_TOL=1).
// A sample-stream model predicts every output each cycle; directed
// frames add literal expectations. Honours PHASE_MON_TIMING_EN.
module tb_phase_clock_monitor;

    localparam int CNT_W     = 2;
    localparam int DWELL_TOL = 1;
`ifdef PHASE_MON_TIMING_EN
    localparam bit TIMING = 1'b1;
`else
    localparam bit TIMING = 1'b0;
`endif

    logic             clk_in;
    logic             rst_n;
    logic             I1, I2, I3;
    logic             busy;
    logic             frame_done;
    logic             frame_err;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] frame_count;

    int checks_total  = 0;
    int checks_passed = 0;
    bit checking      = 1'b0;
    int busy_cycles   = 0;
    int done_seen     = 0;
    int err_seen      = 0;

    // Model: phase 0 = idle, 1..7 = P1..P7, 8 = resync
    int vec_tab [8] = '{0, 1, 5, 4, 6, 2, 3, 1};
    int nom_tab [8] = '{0, 10, 5, 5, 5, 5, 5, 10};
    int m_phase, m_busy, m_done, m_err, m_code, m_count;
    int p_phase, p_done, p_err, p_code, p_count;
    int m_last, m_run;

    phase_clock_monitor #(
        .DWELL_TOL (DWELL_TOL),
        .CNT_W     (CNT_W)
    ) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .I1          (I1),
        .I2          (I2),
        .I3          (I3),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_err   (frame_err),
        .err_code    (err_code),
        .frame_count (frame_count)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks_total++;
        if (actual == expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    // Each call presents vec for n samples and returns 1 time unit after the last sampling edge
    task automatic applyStimulus(input logic [2:0] vec, input int n);
        for (int i = 0; i < n; i++) begin
            {I1, I2, I3} = vec;
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic nominalFrame();
        applyStimulus(3'b001, 10);
        applyStimulus(3'b101, 5);
        applyStimulus(3'b100, 5);
        applyStimulus(3'b110, 5);
        applyStimulus(3'b010, 5);
        applyStimulus(3'b011, 5);
        applyStimulus(3'b001, 10);
        applyStimulus(3'b000, 3);
    endtask

    task automatic clearCounters();
        busy_cycles = 0;
        done_seen   = 0;
        err_seen    = 0;
    endtask

    task automatic modelFault(input int code);
        p_phase = 8;
        p_err   = 1;
        p_code  = code;
    endtask

    // Outputs after an edge are the decision made on the previous sample;
    // the sample taken at this edge decides the outputs after the next edge
    task automatic modelStep();
        int s;
        int nxt;
        int old_run;
        s = int'({I1, I2, I3});
        if (!rst_n) begin
            m_phase = 0; m_busy = 0; m_done = 0; m_err = 0; m_code = 0; m_count = 0;
            p_phase = 0; p_done = 0; p_err = 0; p_code = 0; p_count = 0;
            m_last  = 0; m_run = 0;
            return;
        end
        m_phase = p_phase; m_done = p_done; m_err = p_err; m_code = p_code; m_count = p_count;
        m_busy  = (m_phase >= 1 && m_phase <= 7) ? 1 : 0;
        old_run = m_run;
        m_run   = (s == m_last) ? m_run + 1 : 1;
        p_phase = m_phase; p_done = 0; p_err = 0; p_code = m_code; p_count = m_count;
        if (m_phase == 8) begin
            if (s == 0) p_phase = 0;
        end else if (s != m_last) begin
            nxt = (m_phase + 1) % 8;
            if (s != vec_tab[nxt]) begin
                modelFault(1);
            end else if (TIMING && m_phase != 0 && old_run < nom_tab[m_phase] - DWELL_TOL) begin
                modelFault(2);
            end else begin
                p_phase = nxt;
                if (m_phase == 7) begin
                    p_done  = 1;
                    p_count = (m_count + 1) % (1 << CNT_W);
                end
            end
        end else if (TIMING && m_phase != 0 && m_run >= nom_tab[m_phase] + DWELL_TOL + 1) begin
            modelFault(3);
        end
        m_last = s;
    endtask

    // Model advances on every sampling edge
    initial begin
        forever begin
            @(posedge clk_in);
            modelStep();
        end
    end

    // Per-cycle comparison against the model, away from the sampling edge
    initial begin
        forever begin
            @(negedge clk_in);
            if (checking) begin
                checkOutput("busy",        int'(busy),        m_busy);
                checkOutput("frame_done",  int'(frame_done),  m_done);
                checkOutput("frame_err",   int'(frame_err),   m_err);
                checkOutput("err_code",    int'(err_code),    m_code);
                checkOutput("frame_count", int'(frame_count), m_count);
                if (busy)       busy_cycles++;
                if (frame_done) done_seen++;
                if (frame_err)  err_seen++;
            end
        end
    end

    int exp_counts [5] = '{1, 2, 3, 0, 1};

    // Directed scenarios with hand-computed expectations
    initial begin
        rst_n = 1'b0;
        {I1, I2, I3} = 3'b000;
        applyStimulus(3'b000, 3);
        checkOutput("reset_busy",   int'(busy),        0);
        checkOutput("reset_done",   int'(frame_done),  0);
        checkOutput("reset_err",    int'(frame_err),   0);
        checkOutput("reset_code",   int'(err_code),    0);
        checkOutput("reset_count",  int'(frame_count), 0);
        checking = 1'b1;
        rst_n    = 1'b1;
        applyStimulus(3'b000, 3);

        $display("[TB] nominal frame");
        clearCounters();
        nominalFrame();
        checkOutput("nominal_done_pulses", done_seen,        1);
        checkOutput("nominal_err_pulses",  err_seen,         0);
        checkOutput("nominal_busy_cycles", busy_cycles,      45);
        checkOutput("nominal_count",       int'(frame_count), 1);

        $display("[TB] illegal vector in P3");
        clearCounters();
        applyStimulus(3'b001, 10);
        applyStimulus(3'b101, 5);
        applyStimulus(3'b100, 5);
        applyStimulus(3'b111, 2);
        checkOutput("illegal_code", int'(err_code), 1);
        checkOutput("illegal_busy", int'(busy),     0);
        applyStimulus(3'b000, 3);
        checkOutput("illegal_err_pulses", err_seen, 1);
        nominalFrame();
        checkOutput("after_illegal_count", int'(frame_count), 2);
        checkOutput("after_illegal_done",  done_seen,         1);

`ifdef PHASE_MON_TIMING_EN
        $display("[TB] short P2 dwell");
        clearCounters();
        applyStimulus(3'b001, 10);
        applyStimulus(3'b101, 3);
        applyStimulus(3'b100, 2);
        checkOutput("short_code", int'(err_code), 2);
        applyStimulus(3'b000, 3);
        checkOutput("short_err_pulses", err_seen, 1);

        $display("[TB] long P4 dwell");
        clearCounters();
        applyStimulus(3'b001, 10);
        applyStimulus(3'b101, 5);
        applyStimulus(3'b100, 5);
        applyStimulus(3'b110, 6);
        checkOutput("long_no_early_err", err_seen, 0);
        applyStimulus(3'b110, 3);
        checkOutput("long_err_pulses", err_seen,       1);
        checkOutput("long_code",       int'(err_code), 3);
        applyStimulus(3'b000, 3);
        checkOutput("timing_count", int'(frame_count), 2);
`else
        $display("[TB] long P1 dwell without timing checks");
        clearCounters();
        applyStimulus(3'b001, 40);
        applyStimulus(3'b101, 5);
        applyStimulus(3'b100, 5);
        applyStimulus(3'b110, 5);
        applyStimulus(3'b010, 5);
        applyStimulus(3'b011, 5);
        applyStimulus(3'b001, 10);
        applyStimulus(3'b000, 3);
        checkOutput("long_p1_done", done_seen,         1);
        checkOutput("long_p1_err",  err_seen,          0);
        checkOutput("long_p1_count", int'(frame_count), 3);
`endif

        $display("[TB] frame_count wrap");
        rst_n = 1'b0;
        applyStimulus(3'b000, 2);
        rst_n = 1'b1;
        applyStimulus(3'b000, 2);
        for (int i = 0; i < 5; i++) begin
            nominalFrame();
            checkOutput("count_wrap", int'(frame_count), exp_counts[i]);
        end

        $display("[TB] reset during P5");
        clearCounters();
        applyStimulus(3'b001, 10);
        applyStimulus(3'b101, 5);
        applyStimulus(3'b100, 5);
        applyStimulus(3'b110, 5);
        applyStimulus(3'b010, 2);
        rst_n = 1'b0;
        applyStimulus(3'b010, 1);
        checkOutput("midreset_busy",  int'(busy),        0);
        checkOutput("midreset_done",  int'(frame_done),  0);
        checkOutput("midreset_err",   int'(frame_err),   0);
        checkOutput("midreset_code",  int'(err_code),    0);
        checkOutput("midreset_count", int'(frame_count), 0);
        rst_n = 1'b1;
        applyStimulus(3'b010, 3);
        checkOutput("midreset_fault_code", int'(err_code), 1);
        checkOutput("midreset_err_pulses", err_seen,       1);
        applyStimulus(3'b000, 3);
        nominalFrame();
        checkOutput("midreset_final_count", int'(frame_count), 1);
        checkOutput("midreset_done_pulses", done_seen,         1);

        applyStimulus(3'b000, 2);
        checking = 1'b0;
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
